// File: rtl/midi_tx_pkg.sv
`default_nettype none
// ============================================================================
// midi_tx_pkg : shared MIDI status nibbles, bit rate and byte-serialiser states
// Rev 1.0
// ============================================================================
package midi_tx_pkg;

  localparam logic [3:0] MIDI_NOTE_ON  = 4'h9;
  localparam logic [3:0] MIDI_NOTE_OFF = 4'h8;
  localparam int         MIDI_BAUD     = 31250;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_state_t;

  function automatic logic [7:0] status_byte(input logic on, input logic [3:0] ch);
    return {(on ? MIDI_NOTE_ON : MIDI_NOTE_OFF), ch};
  endfunction

endpackage
`default_nettype wire

// File: rtl/midi_tx_uart_tx_byte.sv
`default_nettype none
// ============================================================================
// uart_tx_byte : 8N1 byte serialiser; a start seen during the last stop-bit
// clock chains the next frame with no idle gap. Rev 1.0
// ============================================================================
module uart_tx_byte
  import midi_tx_pkg::*;
#(
  parameter int DIV = 3200
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [7:0] data,
  output logic       done,
  output logic       tx
);

  localparam int            CW   = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  uart_state_t   state;
  logic [CW-1:0] baud_cnt;
  logic [2:0]    bit_cnt;
  logic [9:0]    shreg;
  logic          bit_end;

  assign bit_end = (state != IDLE) && (baud_cnt == LAST);
  assign done    = bit_end && (state == STOP);
  // Line is the LSB of the frame register; idle/reset value is all ones.
  assign tx      = shreg[0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      baud_cnt <= '0;
      bit_cnt  <= '0;
      shreg    <= '1;
    end else begin
      baud_cnt <= (state == IDLE || bit_end) ? '0 : baud_cnt + 1'b1;
      case (state)
        IDLE: if (start) begin
          shreg <= {1'b1, data, 1'b0};
          state <= START;
        end
        START: if (bit_end) begin
          shreg   <= {1'b1, shreg[9:1]};
          bit_cnt <= '0;
          state   <= DATA;
        end
        DATA: if (bit_end) begin
          shreg   <= {1'b1, shreg[9:1]};
          bit_cnt <= bit_cnt + 1'b1;
          if (bit_cnt == 3'd7) state <= STOP;
        end
        STOP: if (bit_end) begin
          if (start) begin
            shreg <= {1'b1, data, 1'b0};
            state <= START;
          end else begin
            shreg <= '1;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/midi_tx.sv
`default_nettype none
// ============================================================================
// midi_tx : note-on/off request -> 3-byte MIDI message on a 31250 baud line.
// Optional MIDI_TX_RUNNING_STATUS_EN omits a repeated status byte. Rev 1.0
// ============================================================================
module midi_tx
  import midi_tx_pkg::*;
#(
  parameter int CLK_FREQ = 100000000,
  parameter int BAUD     = MIDI_BAUD,
  parameter int CHANNEL  = 0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic       req_on,
  input  logic [7:0] req_key,
  input  logic [6:0] req_vel,
  output logic       tx,
  output logic       busy
);

  localparam int         DIV = CLK_FREQ / BAUD;
  localparam logic [3:0] CH  = 4'(CHANNEL);

  logic [6:0] key_q;
  logic [6:0] vel_q;
  logic [1:0] byte_idx;
  logic       accept;
  logic       byte_start;
  logic       byte_done;
  logic       skip_status;
  logic [7:0] new_status;
  logic [7:0] byte_data;
  logic       unused_key_msb;

  assign unused_key_msb = req_key[7];
  assign new_status     = status_byte(req_on, CH);

`ifdef MIDI_TX_RUNNING_STATUS_EN
  logic [7:0] last_status;
  assign skip_status = (new_status == last_status);
`else
  assign skip_status = 1'b0;
`endif

  assign req_ready  = ~busy;
  assign accept     = req_valid && !busy;
  assign byte_start = accept || (busy && byte_done && (byte_idx != 2'd2));

  // First byte comes straight from the request; later bytes from the latches.
  always_comb begin
    byte_data = {1'b0, vel_q};
    if (accept)
      byte_data = skip_status ? {1'b0, req_key[6:0]} : new_status;
    else if (byte_idx == 2'd0)
      byte_data = {1'b0, key_q};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy     <= 1'b0;
      byte_idx <= 2'd0;
      key_q    <= '0;
      vel_q    <= '0;
`ifdef MIDI_TX_RUNNING_STATUS_EN
      last_status <= 8'h00;
`endif
    end else if (accept) begin
      busy     <= 1'b1;
      byte_idx <= skip_status ? 2'd1 : 2'd0;
      key_q    <= req_key[6:0];
      vel_q    <= req_vel;
`ifdef MIDI_TX_RUNNING_STATUS_EN
      if (!skip_status) last_status <= new_status;
`endif
    end else if (busy && byte_done) begin
      if (byte_idx == 2'd2) busy <= 1'b0;
      else                  byte_idx <= byte_idx + 2'd1;
    end
  end

  uart_tx_byte #(.DIV(DIV)) u_uart (
    .clk   (clk),
    .rst_n (rst_n),
    .start (byte_start),
    .data  (byte_data),
    .done  (byte_done),
    .tx    (tx)
  );

endmodule
`default_nettype wire

// File: tb/tb_midi_tx.sv
`default_nettype none
// ============================================================================
// tb_midi_tx : vector table, corner sequences and random messages checked
// against a per-cycle expected line waveform. Rev 1.0
// ============================================================================
module tb_midi_tx;

  localparam int CLK_FREQ = 1600;
  localparam int BAUD     = 100;
  localparam int CHANNEL  = 5;
  localparam int DIV      = CLK_FREQ / BAUD;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       req_valid = 1'b0;
  logic       req_on = 1'b0;
  logic [7:0] req_key = 8'h00;
  logic [6:0] req_vel = 7'h00;
  logic       req_ready;
  logic       tx;
  logic       busy;

  midi_tx #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD), .CHANNEL(CHANNEL)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_on    (req_on),
    .req_key   (req_key),
    .req_vel   (req_vel),
    .tx        (tx),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          on;
    logic [7:0]  key;
    logic [6:0]  vel;
    logic [23:0] bytes;
  } vec_t;

  vec_t       tab[4];
  int         checks = 0;
  int         failures = 0;
  logic [7:0] m_last_status = 8'h00;
  logic [7:0] exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Reference: message bytes straight from the MIDI rules.
  function automatic void model(input bit on, input logic [7:0] key, input logic [6:0] vel);
    logic [7:0] st;
    st = (on ? 8'h90 : 8'h80) + 8'(CHANNEL);
    exp_q.delete();
`ifdef MIDI_TX_RUNNING_STATUS_EN
    if (st != m_last_status) exp_q.push_back(st);
    m_last_status = st;
`else
    exp_q.push_back(st);
`endif
    exp_q.push_back(key & 8'h7F);
    exp_q.push_back({1'b0, vel});
  endfunction

  function automatic logic line_bit(input int k);
    int         b;
    int         p;
    logic [7:0] cur;
    b = k / 10;
    p = k % 10;
    if (p == 0) return 1'b0;
    if (p == 9) return 1'b1;
    cur = exp_q[b];
    return cur[p-1];
  endfunction

  // Entry: request already driven, between a negedge and the accepting posedge.
  // Exit: at the first idle negedge after the message.
  task automatic check_msg(input string tag, input bit use_tab, input logic [23:0] tb_bytes,
                           input bit hold, input bit n_on, input logic [7:0] n_key,
                           input logic [6:0] n_vel, input int pulse_at);
    int nbits;
    int errs_tx;
    int errs_busy;
    model(req_on, req_key, req_vel);
    if (use_tab) begin
      exp_q.delete();
      exp_q.push_back(tb_bytes[23:16]);
      exp_q.push_back(tb_bytes[15:8]);
      exp_q.push_back(tb_bytes[7:0]);
    end
    nbits     = exp_q.size() * 10;
    errs_tx   = 0;
    errs_busy = 0;
    chk({tag, "_ready_before"}, {31'd0, req_ready}, 32'd1);
    @(posedge clk);
    #1;
    if (hold) begin
      req_on  = n_on;
      req_key = n_key;
      req_vel = n_vel;
    end else begin
      req_valid = 1'b0;
    end
    for (int c = 0; c < nbits * DIV; c++) begin
      @(negedge clk);
      if (c == pulse_at) begin
        req_valid = 1'b1;
        req_on    = n_on;
        req_key   = n_key;
        req_vel   = n_vel;
      end else if (pulse_at >= 0 && c == pulse_at + 1) begin
        req_valid = 1'b0;
      end
      if (tx !== line_bit(c / DIV)) errs_tx++;
      if (busy !== 1'b1 || req_ready !== 1'b0) errs_busy++;
    end
    chk({tag, "_tx_wave_errs"}, errs_tx, 0);
    chk({tag, "_busy_errs"}, errs_busy, 0);
    @(negedge clk);
    chk({tag, "_idle_after"}, {29'd0, busy, req_ready, tx}, 32'b011);
  endtask

  task automatic check_quiet(input string tag, input int n);
    int errs;
    errs = 0;
    repeat (n) begin
      @(negedge clk);
      if (busy !== 1'b0 || tx !== 1'b1 || req_ready !== 1'b1) errs++;
    end
    chk({tag, "_quiet_errs"}, errs, 0);
  endtask

  initial begin
    #10_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    tab[0] = '{1'b1, 8'h3C, 7'h64, 24'h95_3C_64};
    tab[1] = '{1'b0, 8'h95, 7'h40, 24'h85_15_40};
    tab[2] = '{1'b1, 8'h7F, 7'h00, 24'h95_7F_00};
    tab[3] = '{1'b0, 8'h80, 7'h7F, 24'h85_00_7F};

    repeat (3) @(negedge clk);
    chk("reset_state", {29'd0, busy, req_ready, tx}, 32'b011);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 4; i++) begin
      req_valid = 1'b1;
      req_on    = tab[i].on;
      req_key   = tab[i].key;
      req_vel   = tab[i].vel;
      check_msg($sformatf("tab%0d", i), 1'b1, tab[i].bytes, 1'b0, 1'b0, 8'h0, 7'h0, -1);
    end

    // Request pulsed mid-message must be dropped, not queued.
    req_valid = 1'b1; req_on = 1'b1; req_key = 8'h40; req_vel = 7'h22;
    check_msg("pulse", 1'b0, 24'h0, 1'b0, 1'b0, 8'h11, 7'h33, 15 * DIV + 3);
    check_quiet("pulse", 4 * DIV);

    // Held valid: second message starts after exactly one idle clock.
    req_valid = 1'b1; req_on = 1'b0; req_key = 8'h2A; req_vel = 7'h15;
    check_msg("hold_a", 1'b0, 24'h0, 1'b1, 1'b1, 8'hC1, 7'h7E, -1);
    check_msg("hold_b", 1'b0, 24'h0, 1'b0, 1'b0, 8'h00, 7'h00, -1);

    // Reset during byte-1 data bits.
    req_valid = 1'b1; req_on = 1'b0; req_key = 8'h00; req_vel = 7'h55;
    @(posedge clk);
    #1 req_valid = 1'b0;
    repeat (13 * DIV + DIV / 2) @(negedge clk);
    chk("pre_reset", {30'd0, busy, tx}, 32'b10);
    #2 rst_n = 1'b0;
    #1 chk("async_reset", {29'd0, busy, req_ready, tx}, 32'b011);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    m_last_status = 8'h00;
    check_quiet("post_reset", 2 * DIV);
    req_valid = 1'b1; req_on = 1'b0; req_key = 8'h3C; req_vel = 7'h01;
    check_msg("after_reset", 1'b0, 24'h0, 1'b0, 1'b0, 8'h0, 7'h0, -1);

    // Two note-ons then a note-off (status reuse when running status is on).
    req_valid = 1'b1; req_on = 1'b1; req_key = 8'h3C; req_vel = 7'h64;
    check_msg("rs_on1", 1'b0, 24'h0, 1'b0, 1'b0, 8'h0, 7'h0, -1);
    req_valid = 1'b1; req_on = 1'b1; req_key = 8'h40; req_vel = 7'h50;
    check_msg("rs_on2", 1'b0, 24'h0, 1'b0, 1'b0, 8'h0, 7'h0, -1);
`ifdef MIDI_TX_RUNNING_STATUS_EN
    chk("rs_on2_len", exp_q.size(), 2);
`else
    chk("rs_on2_len", exp_q.size(), 3);
`endif
    req_valid = 1'b1; req_on = 1'b0; req_key = 8'h40; req_vel = 7'h00;
    check_msg("rs_off", 1'b0, 24'h0, 1'b0, 1'b0, 8'h0, 7'h0, -1);

    for (int i = 0; i < 8; i++) begin
      req_valid = 1'b1;
      req_on    = 1'($urandom_range(0, 1));
      req_key   = 8'($urandom);
      req_vel   = 7'($urandom);
      check_msg($sformatf("rnd%0d", i), 1'b0, 24'h0, 1'b0, 1'b0, 8'h0, 7'h0, -1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
